// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer bank: register offsets, CTRL fields, MODE codes, FSM states.
package timer_bank_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PSC  = 8;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers and the IDLE/LOAD/CNT/INT FSM.
// Optional per-channel prescaler when TIMER_PRESCALE_EN is defined.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [1:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd_o,
  output logic        irq_o
);
  logic [1:0]       state_q, state_d;
  logic             en_q, en_d, im_q, im_d, pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
  logic             tick, set_pend, wr_ctrl, wr_preset, wr_status;
  logic             unused_wd;

  assign wr_ctrl   = we_i && (reg_i == REG_CTRL);
  assign wr_preset = we_i && (reg_i == REG_PRESET);
  assign wr_status = we_i && (reg_i == REG_STATUS);
  assign unused_wd = ^wdata_i;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_q, psc_d, pcnt_q, pcnt_d;
  assign tick   = (pcnt_q == psc_q);
  assign psc_d  = wr_ctrl ? wdata_i[CTRL_PSC +: 8] : psc_q;
  // Prescaler only runs while counting; any other state restarts it.
  assign pcnt_d = (state_q != ST_CNT || tick) ? 8'd0 : pcnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q  <= '0;
      pcnt_q <= '0;
    end else begin
      psc_q  <= psc_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    set_pend  = 1'b0;
    // A CTRL write overrides the one-shot auto-disable in the INT cycle.
    if (wr_ctrl) begin
      en_d   = wdata_i[CTRL_EN];
      mode_d = wdata_i[CTRL_MODE +: 2];
      im_d   = wdata_i[CTRL_IM];
    end else if (state_q == ST_INT && mode_q != MODE_RELOAD) begin
      en_d = 1'b0;
    end
    if (wr_preset) preset_d = wdata_i[CNT_W-1:0];
    case (state_q)
      ST_IDLE: if (en_q) begin
        state_d = ST_LOAD;
        count_d = preset_q;
      end
      ST_LOAD: begin
        state_d = ST_CNT;
        count_d = preset_q;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            count_d  = '0;
            state_d  = ST_INT;
            set_pend = 1'b1;
          end
        end
      end
      default: begin
        if (en_d && mode_d == MODE_RELOAD) begin
          state_d = ST_LOAD;
          count_d = preset_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    // Setting beats a coincident W1C.
    if (set_pend) pending_d = 1'b1;
    else if (wr_status && wdata_i[0]) pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rd_o = '0;
    case (reg_i)
      REG_CTRL: begin
        rd_o[CTRL_EN]          = en_q;
        rd_o[CTRL_MODE +: 2]   = mode_q;
        rd_o[CTRL_IM]          = im_q;
`ifdef TIMER_PRESCALE_EN
        rd_o[CTRL_PSC +: 8]    = psc_q;
`endif
      end
      REG_PRESET: rd_o[CNT_W-1:0] = preset_q;
      REG_COUNT:  rd_o[CNT_W-1:0] = count_q;
      default:    rd_o[0]         = pending_q;
    endcase
  end

  assign irq_o = pending_q & im_q;
endmodule

// File: rtl/timer_bank.sv
// CH_NUM-channel memory-mapped timer bank: address decode, write steering, read mux, irq vector.
// Prescaler support is built in when TIMER_PRESCALE_EN is defined.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          CH_NUM    = 2,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [CH_NUM-1:0] irq
);
  logic [31:0]              off;
  logic [2:0]               ch_sel;
  logic [1:0]               reg_sel;
  logic                     wr_en;
  logic [CH_NUM-1:0][31:0]  ch_rd;

  // Addresses below BASE_ADDR wrap to large offsets and miss.
  assign off     = addr - BASE_ADDR;
  assign hit     = off < 32'(16 * CH_NUM);
  assign ch_sel  = off[6:4];
  assign reg_sel = off[3:2];
  assign wr_en   = hit && (byteen == 4'hF);

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_en && (ch_sel == 3'(k))),
      .reg_i   (reg_sel),
      .wdata_i (wdata),
      .rd_o    (ch_rd[k]),
      .irq_o   (irq[k])
    );
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < CH_NUM; k++)
      if (hit && ch_sel == 3'(k)) rdata = ch_rd[k];
  end
endmodule
